if_fetch: RTL and testbench

//   Instruction-fetch stage feeding the IF/ID register. It consumes ctrl's stall[5:0], flush and new_pc.

---
 rtl/if_fetch.sv | 166 ++++++++++++++++
 tb/tb_if_fetch.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, runs one request at a time on an SRAM-like
// instruction bus, and registers the fetched slot into the IF/ID outputs.
module if_fetch #(
  parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
  parameter logic [31:0] ADEL_CODE = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic [31:0] if_excepttype,
  output logic        stallreq_from_if
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        cancel_q, cancel_d;
  logic        br_pend_q, br_pend_d;
  logic [31:0] br_tgt_q, br_tgt_d;
  logic [31:0] buf_q, buf_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_exc_q, if_exc_d;

  logic misaligned, slot_ready, br_take, advance;
  logic unused_stall;

  assign unused_stall = ^{stall[5:3], stall[0]};

  assign misaligned = (pc_q[1:0] != 2'b00);
  assign slot_ready = (state_q == DONE) || ((state_q == IDLE) && misaligned);
  assign br_take    = branch_flag_i && !stall[2];
  assign advance    = slot_ready && !stall[1] && !flush;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cancel_d   = cancel_q;
    br_pend_d  = br_pend_q;
    br_tgt_d   = br_tgt_q;
    buf_d      = buf_q;
    req_d      = req_q;
    addr_d     = addr_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;
    if_exc_d   = if_exc_q;

    unique case (state_q)
      IDLE: begin
        if (!flush && !misaligned) begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = REQ;
        end
      end
      REQ: begin
        if (inst_addr_ok) begin
          req_d   = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A response to a cancelled (or just-flushed) request is discarded.
        if (inst_data_ok) begin
          cancel_d = 1'b0;
          if (cancel_q || flush) begin
            state_d = IDLE;
          end else begin
            buf_d   = inst_rdata;
            state_d = DONE;
          end
        end
      end
      DONE: ;
      default: state_d = IDLE;
    endcase

    if (flush) begin
      pc_d       = new_pc;
      br_pend_d  = 1'b0;
      if_valid_d = 1'b0;
      if_inst_d  = 32'h0;
      if_exc_d   = 32'h0;
      if ((state_q == IDLE) || (state_q == DONE)) begin
        state_d = IDLE;
      end else if ((state_q == REQ) || !inst_data_ok) begin
        cancel_d = 1'b1;
      end
    end else if (advance) begin
      if_pc_d    = pc_q;
      if_inst_d  = (state_q == DONE) ? buf_q : 32'h0;
      if_valid_d = 1'b1;
      if_exc_d   = (state_q == DONE) ? 32'h0 : ADEL_CODE;
      pc_d       = br_take ? branch_target_i : (br_pend_q ? br_tgt_q : pc_q + 32'd4);
      br_pend_d  = 1'b0;
      state_d    = IDLE;
    end else begin
      // Branch seen while the delay slot is still in flight: remember it.
      if (br_take) begin
        br_pend_d = 1'b1;
        br_tgt_d  = branch_target_i;
      end
      if (!stall[1]) begin
        if_valid_d = 1'b0;
        if_inst_d  = 32'h0;
        if_exc_d   = 32'h0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      cancel_q   <= 1'b0;
      br_pend_q  <= 1'b0;
      br_tgt_q   <= 32'h0;
      buf_q      <= 32'h0;
      req_q      <= 1'b0;
      addr_q     <= 32'h0;
      if_pc_q    <= 32'h0;
      if_inst_q  <= 32'h0;
      if_valid_q <= 1'b0;
      if_exc_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cancel_q   <= cancel_d;
      br_pend_q  <= br_pend_d;
      br_tgt_q   <= br_tgt_d;
      buf_q      <= buf_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
      if_exc_q   <= if_exc_d;
    end
  end

  assign inst_req         = req_q;
  assign inst_addr        = addr_q;
  assign if_pc            = if_pc_q;
  assign if_inst          = if_inst_q;
  assign if_valid         = if_valid_q;
  assign if_excepttype    = if_exc_q;
  assign stallreq_from_if = rst && !slot_ready;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: the bench plays the instruction bus by hand and
// checks the fetch stage outputs one step at a time.
module tb_if_fetch;

  localparam logic [31:0] K = 32'h55AA_0000;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic [31:0] if_excepttype;
  logic        stallreq_from_if;

  int n_cmp = 0;
  int n_err = 0;

  if_fetch dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .flush            (flush),
    .new_pc           (new_pc),
    .branch_flag_i    (branch_flag_i),
    .branch_target_i  (branch_target_i),
    .inst_req         (inst_req),
    .inst_addr        (inst_addr),
    .inst_addr_ok     (inst_addr_ok),
    .inst_data_ok     (inst_data_ok),
    .inst_rdata       (inst_rdata),
    .if_pc            (if_pc),
    .if_inst          (if_inst),
    .if_valid         (if_valid),
    .if_excepttype    (if_excepttype),
    .stallreq_from_if (stallreq_from_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_req(input logic [31:0] a);
    int n = 0;
    while (inst_req !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk("req_seen", {31'h0, inst_req}, 32'h1);
    chk("req_addr", inst_addr, a);
  endtask

  task automatic serve(input logic [31:0] a, input int a_dly, input int d_dly);
    inst_addr_ok = 1'b0;
    for (int i = 0; i < a_dly; i++) begin
      tick();
      chk("req_hold", {31'h0, inst_req}, 32'h1);
      chk("addr_hold", inst_addr, a);
    end
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    chk("req_drop", {31'h0, inst_req}, 32'h0);
    for (int i = 0; i < d_dly; i++) begin
      tick();
      chk("wait_stallreq", {31'h0, stallreq_from_if}, 32'h1);
      chk("wait_bubble", {31'h0, if_valid}, 32'h0);
      chk("wait_addr", inst_addr, a);
    end
    inst_data_ok = 1'b1;
    inst_rdata   = a ^ K;
    tick();
    inst_data_ok = 1'b0;
    inst_rdata   = 32'h0;
  endtask

  task automatic deliver(input logic [31:0] a);
    chk("slot_ready", {31'h0, stallreq_from_if}, 32'h0);
    tick();
    chk("dlv_valid", {31'h0, if_valid}, 32'h1);
    chk("dlv_pc", if_pc, a);
    chk("dlv_inst", if_inst, a ^ K);
    chk("dlv_exc", if_excepttype, 32'h0);
  endtask

  initial begin
    rst = 1'b0; stall = 6'h0; flush = 1'b0; new_pc = 32'h0;
    branch_flag_i = 1'b0; branch_target_i = 32'h0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;

    // Reset values
    #22;
    chk("rst_req", {31'h0, inst_req}, 32'h0);
    chk("rst_addr", inst_addr, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_inst", if_inst, 32'h0);
    chk("rst_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_exc", if_excepttype, 32'h0);
    chk("rst_stallreq", {31'h0, stallreq_from_if}, 32'h0);
    rst = 1'b1;

    // Zero-wait sequential fetches
    expect_req(32'hBFC0_0000);
    serve(32'hBFC0_0000, 0, 0);
    deliver(32'hBFC0_0000);
    expect_req(32'hBFC0_0004);
    serve(32'hBFC0_0004, 0, 0);
    deliver(32'hBFC0_0004);

    // Branch while the delay slot BFC00008 waits for data
    expect_req(32'hBFC0_0008);
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    branch_flag_i = 1'b1; branch_target_i = 32'hBFC0_0100;
    tick();
    branch_flag_i = 1'b0; branch_target_i = 32'h0;
    chk("br_bubble", {31'h0, if_valid}, 32'h0);
    inst_data_ok = 1'b1; inst_rdata = 32'hBFC0_0008 ^ K;
    tick();
    inst_data_ok = 1'b0; inst_rdata = 32'h0;
    deliver(32'hBFC0_0008);
    expect_req(32'hBFC0_0100);
    serve(32'hBFC0_0100, 0, 0);
    deliver(32'hBFC0_0100);

    // Slow data, then a branch taken in the same cycle as the delivery
    expect_req(32'hBFC0_0104);
    serve(32'hBFC0_0104, 0, 4);
    branch_flag_i = 1'b1; branch_target_i = 32'hBFC0_0200;
    deliver(32'hBFC0_0104);
    branch_flag_i = 1'b0; branch_target_i = 32'h0;

    // Flush in WAIT; stale response two cycles later must be dropped
    expect_req(32'hBFC0_0200);
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    flush = 1'b1; new_pc = 32'hBFC0_0380;
    tick();
    flush = 1'b0; new_pc = 32'h0;
    chk("flw_valid", {31'h0, if_valid}, 32'h0);
    tick();
    chk("flw_stallreq", {31'h0, stallreq_from_if}, 32'h1);
    inst_data_ok = 1'b1; inst_rdata = 32'hBFC0_0200 ^ K;
    tick();
    inst_data_ok = 1'b0; inst_rdata = 32'h0;
    chk("flw_stale_valid", {31'h0, if_valid}, 32'h0);
    chk("flw_stale_inst", if_inst, 32'h0);
    expect_req(32'hBFC0_0380);
    chk("flw_no_dlv", {31'h0, if_valid}, 32'h0);
    serve(32'hBFC0_0380, 0, 0);
    deliver(32'hBFC0_0380);

    // Flush in REQ with addr_ok low for 3 cycles
    expect_req(32'hBFC0_0384);
    flush = 1'b1; new_pc = 32'hBFC0_0400;
    tick();
    flush = 1'b0; new_pc = 32'h0;
    chk("flr_req1", {31'h0, inst_req}, 32'h1);
    chk("flr_addr1", inst_addr, 32'hBFC0_0384);
    tick();
    chk("flr_req2", {31'h0, inst_req}, 32'h1);
    chk("flr_addr2", inst_addr, 32'hBFC0_0384);
    tick();
    chk("flr_req3", {31'h0, inst_req}, 32'h1);
    chk("flr_addr3", inst_addr, 32'hBFC0_0384);
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    chk("flr_req_drop", {31'h0, inst_req}, 32'h0);
    inst_data_ok = 1'b1; inst_rdata = 32'hBFC0_0384 ^ K;
    tick();
    inst_data_ok = 1'b0; inst_rdata = 32'h0;
    chk("flr_stale_valid", {31'h0, if_valid}, 32'h0);
    expect_req(32'hBFC0_0400);
    serve(32'hBFC0_0400, 0, 0);
    deliver(32'hBFC0_0400);

    // Flush to a misaligned PC: exception slot without a bus request
    flush = 1'b1; new_pc = 32'hBFC0_0382;
    tick();
    flush = 1'b0; new_pc = 32'h0;
    chk("adel_flush_valid", {31'h0, if_valid}, 32'h0);
    chk("adel_noreq0", {31'h0, inst_req}, 32'h0);
    chk("adel_ready", {31'h0, stallreq_from_if}, 32'h0);
    tick();
    chk("adel_valid", {31'h0, if_valid}, 32'h1);
    chk("adel_pc", if_pc, 32'hBFC0_0382);
    chk("adel_inst", if_inst, 32'h0);
    chk("adel_exc", if_excepttype, 32'h0000_0004);
    stall = 6'b000011;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("hold_valid", {31'h0, if_valid}, 32'h1);
      chk("hold_pc", if_pc, 32'hBFC0_0382);
      chk("hold_exc", if_excepttype, 32'h0000_0004);
      chk("hold_noreq", {31'h0, inst_req}, 32'h0);
    end
    stall = 6'h0;
    tick();
    chk("adel2_pc", if_pc, 32'hBFC0_0386);
    chk("adel2_exc", if_excepttype, 32'h0000_0004);
    chk("adel2_valid", {31'h0, if_valid}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
